// File: rtl/stage_memory_pkg.sv
// stage_memory_pkg: shared CPU types and constants for the memory-access stage
package stage_memory_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] regaddr_t;
  localparam word_t NOP_PC = 32'hFFFF_FFFF;
  localparam word_t NOP_IR = 32'h0000_0013;
  typedef enum logic [2:0] {MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU} ma_size_t;
  typedef enum logic [1:0] {MA_NONE, MA_LOAD, MA_STORE} ma_mode_t;
  typedef enum logic {MS_IDLE, MS_WAIT} ms_state_t;
endpackage

// File: rtl/stage_memory_store_align.sv
// store_align: byte-lane placement, write mask and misalignment detection for one access
module store_align
  import stage_memory_pkg::*;
(
  input  ma_size_t    size_i,
  input  logic [1:0]  align_i,
  input  word_t       data_i,
  output word_t       lane_data_o,
  output logic [3:0]  lane_mask_o,
  output logic        misaligned_o
);
  logic is_b, is_h;
  assign is_b = size_i == MA_SIZE_B || size_i == MA_SIZE_BU;
  assign is_h = size_i == MA_SIZE_H || size_i == MA_SIZE_HU;
  // Bytes are replicated into every lane; halves are replicated and shifted into place.
  always_comb begin
    lane_mask_o = is_b ? 4'b0001 << align_i : is_h ? 4'b0011 << align_i : 4'b1111;
    lane_data_o = is_b ? {4{data_i[7:0]}} : is_h ? {2{data_i[15:0]}} << {align_i, 3'b000} : data_i;
    misaligned_o = is_h ? align_i == 2'd3 : !is_b && align_i != 2'd0;
  end
endmodule

// File: rtl/stage_memory.sv
// stage_memory: RISC-V memory-access stage driving a ready-handshaked dmem port
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  word_t       pc_i,
  input  word_t       ir_i,
  input  ma_mode_t    ma_mode_i,
  input  ma_size_t    ma_size_i,
  input  word_t       alu_result_i,
  input  word_t       store_data_i,
  input  regaddr_t    wb_addr_i,
  input  logic        wb_valid_i,
  input  logic        wb_ready_i,
  input  logic        dmem_ready_i,
  output word_t       dmem_addr_o,
  output logic        dmem_req_o,
  output word_t       dmem_write_data_o,
  output logic [3:0]  dmem_write_mask_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_fault_o,
  output logic        empty_async_o,
  output word_t       pc_o,
  output word_t       ir_o,
  output logic        load_o,
  output ma_size_t    ma_size_o,
  output logic [1:0]  ma_alignment_o,
  output regaddr_t    wb_addr_o,
  output word_t       wb_data_o,
  output logic        wb_ready_o,
  output logic        wb_valid_o
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  ms_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] lane_mask;
  logic mis, access, is_load, accept, timeout, pass;

  store_align u_store_align (
    .size_i       (ma_size_i),
    .align_i      (alu_result_i[1:0]),
    .data_i       (store_data_i),
    .lane_data_o  (dmem_write_data_o),
    .lane_mask_o  (lane_mask),
    .misaligned_o (mis)
  );

  // Execute holds its outputs while stalled, so request fields come straight from the inputs in both states.
  assign access = ma_mode_i != MA_NONE;
  assign is_load = ma_mode_i == MA_LOAD;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
  assign dmem_req_o = access && !mis;
  assign dmem_write_mask_o = dmem_req_o && ma_mode_i == MA_STORE ? lane_mask : 4'b0000;
  assign accept = dmem_req_o && dmem_ready_i;
  assign timeout = TIMEOUT_CYCLES != 0 && state == MS_WAIT && !dmem_ready_i && cnt == CW'(TIMEOUT_CYCLES);
  assign stall_o = dmem_req_o && !dmem_ready_i && !timeout;
  assign pass = !access || accept;
  assign empty_async_o = pc_i == NOP_PC;

  // Next state: any not-ready request waits and counts; acceptance or timeout returns to idle.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept || timeout) begin
      state_n = MS_IDLE;
      cnt_n = '0;
    end else if (dmem_req_o) begin
      state_n = MS_WAIT;
      cnt_n = cnt + 1'b1;
    end
  end

  // State and wait-cycle counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= MS_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end

  // Writeback register: pass through completed instructions, otherwise insert a bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !pass) begin
      pc_o <= NOP_PC;
      ir_o <= NOP_IR;
      load_o <= 1'b0;
      ma_size_o <= MA_SIZE_W;
      ma_alignment_o <= 2'b00;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_ready_o <= 1'b0;
      wb_valid_o <= 1'b0;
    end else begin
      pc_o <= pc_i;
      ir_o <= ir_i;
      load_o <= is_load;
      ma_size_o <= ma_size_i;
      ma_alignment_o <= alu_result_i[1:0];
      wb_addr_o <= wb_addr_i;
      wb_data_o <= alu_result_i;
      wb_ready_o <= wb_ready_i && !is_load;
      wb_valid_o <= wb_valid_i;
    end
  end

  // One-cycle fault pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misaligned_o <= 1'b0;
      bus_fault_o <= 1'b0;
    end else begin
      misaligned_o <= access && mis;
      bus_fault_o <= timeout;
    end
  end
endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: directed and randomized checks of stage_memory against a byte-lane reference model
module tb_stage_memory;
  import stage_memory_pkg::*;
  localparam int TO = 4;
  logic clk = 0, rst_ni = 0;
  word_t pc_i = 0, ir_i = 0, alu_result_i = 0, store_data_i = 0;
  ma_mode_t ma_mode_i = MA_NONE;
  ma_size_t ma_size_i = MA_SIZE_W;
  regaddr_t wb_addr_i = 0;
  logic wb_valid_i = 0, wb_ready_i = 0, dmem_ready_i = 0;
  word_t dmem_addr_o, dmem_write_data_o, pc_o, ir_o, wb_data_o;
  logic dmem_req_o, stall_o, misaligned_o, bus_fault_o, empty_async_o, load_o, wb_ready_o, wb_valid_o;
  logic [3:0] dmem_write_mask_o;
  ma_size_t ma_size_o;
  logic [1:0] ma_alignment_o;
  regaddr_t wb_addr_o;
  int checks = 0, errors = 0;

  stage_memory #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pc_i(pc_i), .ir_i(ir_i), .ma_mode_i(ma_mode_i),
    .ma_size_i(ma_size_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .wb_addr_i(wb_addr_i), .wb_valid_i(wb_valid_i), .wb_ready_i(wb_ready_i),
    .dmem_ready_i(dmem_ready_i), .dmem_addr_o(dmem_addr_o), .dmem_req_o(dmem_req_o),
    .dmem_write_data_o(dmem_write_data_o), .dmem_write_mask_o(dmem_write_mask_o),
    .stall_o(stall_o), .misaligned_o(misaligned_o), .bus_fault_o(bus_fault_o),
    .empty_async_o(empty_async_o), .pc_o(pc_o), .ir_o(ir_o), .load_o(load_o),
    .ma_size_o(ma_size_o), .ma_alignment_o(ma_alignment_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_ready_o(wb_ready_o), .wb_valid_o(wb_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input word_t pc, input ma_mode_t m, input ma_size_t s, input word_t a,
                       input word_t d, input regaddr_t wa, input logic wv, input logic wr, input logic rdy);
    pc_i = pc; ir_i = pc ^ 32'h5A5A_0000; ma_mode_i = m; ma_size_i = s; alu_result_i = a;
    store_data_i = d; wb_addr_i = wa; wb_valid_i = wv; wb_ready_i = wr; dmem_ready_i = rdy;
    #1;
  endtask

  function automatic int nbytes(input ma_size_t s);
    return (s == MA_SIZE_B || s == MA_SIZE_BU) ? 1 : (s == MA_SIZE_H || s == MA_SIZE_HU) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_mask(input ma_size_t s, input logic [1:0] al);
    logic [3:0] m = 0;
    for (int k = 0; k < 4; k++) if (k >= al && k < al + nbytes(s)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic word_t lane_bits(input logic [3:0] m);
    word_t r = 0;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic word_t exp_lanes(input ma_size_t s, input logic [1:0] al, input word_t d);
    word_t r = 0;
    for (int k = 0; k < 4; k++) if (k >= al && k < al + nbytes(s)) r[8*k +: 8] = d[8*(k - al) +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst_ni = 0;
    drive(32'h100, MA_STORE, MA_SIZE_W, 32'h40, 32'h1, 5'd3, 1, 1, 1);
    tick(); tick();
    checks++; if (pc_o !== NOP_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, NOP_PC); end
    checks++; if (ir_o !== NOP_IR) begin errors++; $display("FAIL reset_ir: got %h want %h", ir_o, NOP_IR); end
    checks++; if ({load_o, wb_valid_o, wb_ready_o, misaligned_o, bus_fault_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {load_o, wb_valid_o, wb_ready_o, misaligned_o, bus_fault_o}); end
    checks++; if (wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin errors++; $display("FAIL reset_wb: got %h/%h want 0/0", wb_addr_o, wb_data_o); end
    checks++; if (ma_size_o !== MA_SIZE_W || ma_alignment_o !== 2'd0) begin errors++; $display("FAIL reset_size: got %0d/%0d want %0d/0", ma_size_o, ma_alignment_o, MA_SIZE_W); end
    drive(32'h0, MA_NONE, MA_SIZE_W, 0, 0, 0, 0, 0, 1);
    rst_ni = 1;
    tick();
  endtask

  task automatic test_alu();
    drive(32'h200, MA_NONE, MA_SIZE_W, 32'h1234, 32'hDEAD, 5'd7, 1, 1, 0);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL alu_noreq: got req=%b stall=%b want 0/0", dmem_req_o, stall_o); end
    tick();
    checks++; if (wb_data_o !== 32'h1234 || wb_addr_o !== 5'd7) begin errors++; $display("FAIL alu_wb: got %h/%0d want 1234/7", wb_data_o, wb_addr_o); end
    checks++; if (wb_valid_o !== 1'b1 || wb_ready_o !== 1'b1 || load_o !== 1'b0) begin errors++; $display("FAIL alu_flags: got v=%b r=%b l=%b want 1/1/0", wb_valid_o, wb_ready_o, load_o); end
    checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL alu_pc: got %h want 200", pc_o); end
  endtask

  task automatic test_sb();
    drive(32'h300, MA_STORE, MA_SIZE_B, 32'h1003, 32'h0000_00AB, 5'd0, 0, 0, 1);
    checks++; if (dmem_addr_o !== 32'h1000) begin errors++; $display("FAIL sb_addr: got %h want 1000", dmem_addr_o); end
    checks++; if (dmem_write_mask_o !== 4'b1000) begin errors++; $display("FAIL sb_mask: got %b want 1000", dmem_write_mask_o); end
    checks++; if (dmem_write_data_o !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_data: got %h want abababab", dmem_write_data_o); end
    checks++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL sb_req: got req=%b stall=%b want 1/0", dmem_req_o, stall_o); end
    tick();
    checks++; if (pc_o !== 32'h300 || load_o !== 1'b0) begin errors++; $display("FAIL sb_out: got pc=%h load=%b want 300/0", pc_o, load_o); end
  endtask

  task automatic test_lw_wait();
    drive(32'h400, MA_LOAD, MA_SIZE_W, 32'h2000, 0, 5'd9, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1) begin errors++; $display("FAIL lw_stall%0d: got stall=%b req=%b want 1/1", i, stall_o, dmem_req_o); end
      tick();
      checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL lw_bubble%0d: got pc=%h v=%b want %h/0", i, pc_o, wb_valid_o, NOP_PC); end
    end
    dmem_ready_i = 1; #1;
    checks++; if (stall_o !== 1'b0 || dmem_write_mask_o !== 4'b0) begin errors++; $display("FAIL lw_accept: got stall=%b mask=%b want 0/0000", stall_o, dmem_write_mask_o); end
    tick();
    checks++; if (load_o !== 1'b1 || ma_alignment_o !== 2'd0 || wb_ready_o !== 1'b0) begin errors++; $display("FAIL lw_out: got l=%b al=%0d r=%b want 1/0/0", load_o, ma_alignment_o, wb_ready_o); end
    checks++; if (pc_o !== 32'h400 || wb_data_o !== 32'h2000) begin errors++; $display("FAIL lw_pc: got %h/%h want 400/2000", pc_o, wb_data_o); end
  endtask

  task automatic test_misaligned();
    drive(32'h500, MA_LOAD, MA_SIZE_H, 32'h2003, 0, 5'd4, 1, 1, 1);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o); end
    tick();
    checks++; if (misaligned_o !== 1'b1 || pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL mis_pulse: got m=%b pc=%h v=%b want 1/%h/0", misaligned_o, pc_o, wb_valid_o, NOP_PC); end
    drive(32'h504, MA_NONE, MA_SIZE_W, 0, 0, 0, 0, 0, 1);
    tick();
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misaligned_o); end
  endtask

  task automatic test_timeout();
    drive(32'h600, MA_STORE, MA_SIZE_W, 32'h3000, 32'h1111_2222, 0, 0, 0, 0);
    tick();
    for (int i = 1; i < TO; i++) begin
      checks++; if (stall_o !== 1'b1 || dmem_write_mask_o !== 4'hF) begin errors++; $display("FAIL to_wait%0d: got stall=%b mask=%b want 1/1111", i, stall_o, dmem_write_mask_o); end
      tick();
      checks++; if (bus_fault_o !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b want 0", i, bus_fault_o); end
    end
    tick();
    checks++; if (bus_fault_o !== 1'b1 || pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL to_fault: got f=%b pc=%h v=%b want 1/%h/0", bus_fault_o, pc_o, wb_valid_o, NOP_PC); end
    drive(32'h604, MA_NONE, MA_SIZE_W, 0, 0, 0, 0, 0, 0);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL to_idle: got req=%b stall=%b want 0/0", dmem_req_o, stall_o); end
    tick();
    checks++; if (bus_fault_o !== 1'b0 || pc_o !== 32'h604) begin errors++; $display("FAIL to_after: got f=%b pc=%h want 0/604", bus_fault_o, pc_o); end
  endtask

  task automatic test_reset_mid_wait();
    drive(32'h700, MA_STORE, MA_SIZE_W, 32'h4000, 32'h5, 0, 1, 1, 0);
    tick();
    rst_ni = 0;
    drive(32'h0, MA_NONE, MA_SIZE_W, 0, 0, 0, 0, 0, 0);
    tick();
    rst_ni = 1; #1;
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rw_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o); end
    checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rw_out: got pc=%h v=%b want %h/0", pc_o, wb_valid_o, NOP_PC); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ma_mode_t m = ma_mode_t'($urandom_range(0, 2));
      ma_size_t s = ma_size_t'($urandom_range(0, 4));
      word_t pc = $urandom & 32'hFFFF_FFFC, a = $urandom, d = $urandom;
      regaddr_t wa = regaddr_t'($urandom);
      logic wv = 1'($urandom), wr = 1'($urandom);
      int dly = $urandom_range(0, 3);
      logic [1:0] al = a[1:0];
      logic bad = m != MA_NONE && al + nbytes(s) > 4;
      logic [3:0] em = m == MA_STORE && !bad ? exp_mask(s, al) : 4'b0;
      drive(pc, m, s, a, d, wa, wv, wr, m == MA_NONE || bad || dly == 0);
      if (m != MA_NONE && !bad) begin
        for (int i = 0; i < dly; i++) begin
          checks++; if (!dmem_req_o || !stall_o || dmem_addr_o !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_wait%0d: got req=%b stall=%b addr=%h want 1/1/%h", n, dmem_req_o, stall_o, dmem_addr_o, {a[31:2], 2'b00}); end
          tick();
          checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_bubble%0d: got pc=%h v=%b", n, pc_o, wb_valid_o); end
          if (i == dly - 1) begin dmem_ready_i = 1; #1; end
        end
      end
      checks++; if (dmem_req_o !== (m != MA_NONE && !bad) || stall_o !== 1'b0 || dmem_write_mask_o !== em) begin errors++; $display("FAIL rnd_req%0d: got req=%b stall=%b mask=%b want %b/0/%b", n, dmem_req_o, stall_o, dmem_write_mask_o, m != MA_NONE && !bad, em); end
      checks++; if ((dmem_write_data_o & lane_bits(em)) !== (exp_lanes(s, al, d) & lane_bits(em))) begin errors++; $display("FAIL rnd_data%0d: got %h want %h under mask %b", n, dmem_write_data_o, exp_lanes(s, al, d), em); end
      tick();
      if (bad) begin
        checks++; if (misaligned_o !== 1'b1 || pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_mis%0d: got m=%b pc=%h v=%b want 1/%h/0", n, misaligned_o, pc_o, wb_valid_o, NOP_PC); end
      end else begin
        checks++; if (pc_o !== pc || wb_data_o !== a || wb_addr_o !== wa || wb_valid_o !== wv || misaligned_o !== 1'b0) begin errors++; $display("FAIL rnd_out%0d: got pc=%h d=%h a=%0d v=%b want %h/%h/%0d/%b", n, pc_o, wb_data_o, wb_addr_o, wb_valid_o, pc, a, wa, wv); end
        checks++; if (load_o !== (m == MA_LOAD) || wb_ready_o !== (wr && m != MA_LOAD) || ma_size_o !== s || ma_alignment_o !== al) begin errors++; $display("FAIL rnd_flags%0d: got l=%b r=%b sz=%0d al=%0d want %b/%b/%0d/%0d", n, load_o, wb_ready_o, ma_size_o, ma_alignment_o, m == MA_LOAD, wr && m != MA_LOAD, s, al); end
      end
      checks++; if (empty_async_o !== (pc_i == NOP_PC)) begin errors++; $display("FAIL rnd_empty%0d: got %b", n, empty_async_o); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sb();
    test_lw_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
